// File: rtl/cnu_pkg.sv
// cnu_pkg: shared constants and helpers for the check-node min-finder blocks
package cnu_pkg;

    localparam int DATA_W_DEF = 9;
    localparam logic [DATA_W_DEF-1:0] MAG_MAX = '1;

    localparam logic IDLE = 1'b0;
    localparam logic ACC  = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/min2_step.sv
// min2_step: one combinational beat of the running two-smallest tracker
module min2_step #(
    parameter int DATA_W = 9,
    parameter int IDX_W = 5
) (
    input  logic [DATA_W-1:0] min1,
    input  logic [DATA_W-1:0] min2,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] x,
    input  logic [IDX_W-1:0]  cnt,
    output logic [DATA_W-1:0] min1_n,
    output logic [DATA_W-1:0] min2_n,
    output logic [IDX_W-1:0]  idx_n
);

    logic lt1, lt2;

    // Strict compares so the earliest of equal magnitudes keeps min1
    always_comb begin
        lt1 = x < min1;
        lt2 = x < min2;
        min1_n = lt1 ? x : min1;
        min2_n = lt1 ? min1 : (lt2 ? x : min2);
        idx_n = lt1 ? cnt : idx;
    end

endmodule

// File: rtl/min2_serial.sv
// min2_serial: streams row magnitudes, emits min1/min2/idx/degree per row
// Optional sign parity tracking is built when MIN2_SIGN_EN is defined.
module min2_serial import cnu_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEG_MAX = 32,
    localparam int IDX_W = idx_w(DEG_MAX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
`ifdef MIN2_SIGN_EN
    input  logic              in_sign,
    output logic              out_sign,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min1,
    output logic [DATA_W-1:0] out_min2,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W:0]    out_deg,
    output logic              out_ovf
);

    localparam logic [DATA_W-1:0] ONES = '1;
    localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(DEG_MAX);

    logic state_q, state_d, rdy_q, rdy_d, ovf_q, ovf_d;
    logic [IDX_W:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] min1_q, min1_d, min2_q, min2_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
    logic [DATA_W-1:0] out_min1_q, out_min1_d, out_min2_q, out_min2_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W:0] out_deg_q, out_deg_d;

    logic accept, take_last, excess, in_acc;
    logic [IDX_W:0] cur_cnt;
    logic [DATA_W-1:0] cur_min1, cur_min2, step_min1, step_min2, upd_min1, upd_min2;
    logic [IDX_W-1:0] cur_idx, step_idx, upd_idx;

    assign in_acc = state_q == ACC;
    assign in_ready = rdy_q && !(out_valid_q && !out_ready && in_last);
    assign accept = in_valid && in_ready;
    assign take_last = accept && in_last;
    assign cur_cnt = in_acc ? cnt_q : '0;
    assign cur_min1 = in_acc ? min1_q : ONES;
    assign cur_min2 = in_acc ? min2_q : ONES;
    assign cur_idx = in_acc ? idx_q : '0;
    assign excess = cur_cnt == CNT_MAX;

    min2_step #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_step (
        .min1   (cur_min1),
        .min2   (cur_min2),
        .idx    (cur_idx),
        .x      (in_data),
        .cnt    (cur_cnt[IDX_W-1:0]),
        .min1_n (step_min1),
        .min2_n (step_min2),
        .idx_n  (step_idx)
    );

    assign upd_min1 = excess ? cur_min1 : step_min1;
    assign upd_min2 = excess ? cur_min2 : step_min2;
    assign upd_idx = excess ? cur_idx : step_idx;

    assign out_valid = out_valid_q;
    assign out_min1 = out_min1_q;
    assign out_min2 = out_min2_q;
    assign out_idx = out_idx_q;
    assign out_deg = out_deg_q;
    assign out_ovf = out_ovf_q;

    // Accumulate accepted beats; a last beat publishes and restarts the row
    always_comb begin
        rdy_d = 1'b1;
        state_d = take_last ? IDLE : (accept ? ACC : state_q);
        cnt_d = take_last ? '0 : (accept ? (excess ? cur_cnt : cur_cnt + 1'b1) : cnt_q);
        min1_d = take_last ? ONES : (accept ? upd_min1 : min1_q);
        min2_d = take_last ? ONES : (accept ? upd_min2 : min2_q);
        idx_d = take_last ? '0 : (accept ? upd_idx : idx_q);
        ovf_d = take_last ? 1'b0 : (accept ? ((in_acc && ovf_q) || excess) : ovf_q);
        out_valid_d = take_last || (out_valid_q && !out_ready);
        out_min1_d = take_last ? upd_min1 : out_min1_q;
        out_min2_d = take_last ? upd_min2 : out_min2_q;
        out_idx_d = take_last ? upd_idx : out_idx_q;
        out_deg_d = take_last ? (excess ? cur_cnt : cur_cnt + 1'b1) : out_deg_q;
        out_ovf_d = take_last ? ((in_acc && ovf_q) || excess) : out_ovf_q;
    end

    // State registers; reset drops any partial row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            state_q <= IDLE;
            cnt_q <= '0;
            min1_q <= ONES;
            min2_q <= ONES;
            idx_q <= '0;
            ovf_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_min1_q <= '0;
            out_min2_q <= '0;
            out_idx_q <= '0;
            out_deg_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            rdy_q <= rdy_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
            min1_q <= min1_d;
            min2_q <= min2_d;
            idx_q <= idx_d;
            ovf_q <= ovf_d;
            out_valid_q <= out_valid_d;
            out_min1_q <= out_min1_d;
            out_min2_q <= out_min2_d;
            out_idx_q <= out_idx_d;
            out_deg_q <= out_deg_d;
            out_ovf_q <= out_ovf_d;
        end
    end

`ifdef MIN2_SIGN_EN
    logic sign_q, sign_d, out_sign_q, out_sign_d, upd_sign;

    assign upd_sign = (in_acc && sign_q) ^ (in_sign && !excess);
    assign out_sign = out_sign_q;

    // Sign parity over the non-excess beats of the row
    always_comb begin
        sign_d = take_last ? 1'b0 : (accept ? upd_sign : sign_q);
        out_sign_d = take_last ? upd_sign : out_sign_q;
    end

    // Sign registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            out_sign_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
            out_sign_q <= out_sign_d;
        end
    end
`endif

endmodule
